// File: rtl/audio_playback_scheduler.sv
// audio_playback_scheduler: derives the sample tick from clk_27MHz, fetches one
// sample per tick over a req/ack handshake, strobes it toward the DAC, and runs
// the play/pause/stop transport with track selection and looping.
module audio_playback_scheduler #(
  parameter int                 TICK_DIV    = 1227,
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 8,
  parameter int                 NUM_TRACKS  = 4,
  parameter int                 TRACK_WORDS = 16384,
  parameter logic [DATA_W-1:0]  MIDSCALE    = DATA_W'(8'h80),
  localparam int                SEL_W       = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic              clk_27MHz,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [SEL_W-1:0]  track_sel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

  localparam int                CNT_W    = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CNT_W-1:0]  TICK_MAX = CNT_W'(TICK_DIV);
  localparam logic [ADDR_W-1:0] TW       = ADDR_W'(TRACK_WORDS);
  localparam logic [ADDR_W-1:0] TW_M1    = ADDR_W'(TRACK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, FETCH, PAUSED} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                pend_q, pend_d;
  logic                stop_lat_q, stop_lat_d;
  logic                pause_lat_q, pause_lat_d;

  logic                running;
  logic                tick;
  logic                ack;
  logic                stop_any;
  logic                pause_any;
  logic                last_word;
  logic [ADDR_W-1:0]   sel_base;

  assign running   = (state_q == WAIT_TICK) || (state_q == FETCH);
  assign tick      = running && (cnt_q == TICK_MAX);
  // An ack only means something while a request is actually outstanding.
  assign ack       = mem_ack && mem_req_q;
  assign stop_any  = stop  || stop_lat_q;
  assign pause_any = pause || pause_lat_q;
  assign last_word = (addr_q == (base_q + TW_M1));
  assign sel_base  = ADDR_W'(track_sel) * TW;

  // Next-state and output decode for the transport/fetch sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    base_d      = base_q;
    mem_req_d   = mem_req_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    pend_d      = pend_q;
    stop_lat_d  = stop_lat_q;
    pause_lat_d = pause_lat_q;

    // The tick counter free-runs whenever playback is active, including fetches.
    if (running) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        sample_d  = MIDSCALE;
        mem_req_d = 1'b0;
        if (play && !pause && !stop) begin
          base_d      = sel_base;
          addr_d      = sel_base;
          cnt_d       = '0;
          overrun_d   = 1'b0;
          pend_d      = 1'b0;
          stop_lat_d  = 1'b0;
          pause_lat_d = 1'b0;
          state_d     = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (stop) begin
          sample_d = MIDSCALE;
          state_d  = IDLE;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          mem_req_d   = 1'b1;
          stop_lat_d  = 1'b0;
          pause_lat_d = 1'b0;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        // One tick may wait behind the current fetch; a second one is lost.
        if (tick) begin
          if (pend_q) overrun_d = 1'b1;
          else        pend_d    = 1'b1;
        end
        if (ack) begin
          mem_req_d   = 1'b0;
          stop_lat_d  = 1'b0;
          pause_lat_d = 1'b0;
          if (stop_any) begin
            sample_d = MIDSCALE;
            pend_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            sample_d = mem_data;
            valid_d  = 1'b1;
            if (last_word && !loop_en) begin
              // Final sample is strobed now; IDLE swaps in silence next cycle.
              done_d  = 1'b1;
              pend_d  = 1'b0;
              state_d = IDLE;
            end else begin
              addr_d = last_word ? base_q : addr_q + ADDR_W'(1);
              pend_d = 1'b0;
              if (pause_any)          state_d = PAUSED;
              else if (pend_q || tick) state_d = FETCH;
              else                    state_d = WAIT_TICK;
            end
          end
        end else begin
          stop_lat_d  = stop_lat_q  || stop;
          pause_lat_d = pause_lat_q || pause;
          // Request dropped after a back-to-back ack: reissue unless a control
          // arrived, since nothing is outstanding to wait for.
          if (!mem_req_q) begin
            if (stop_any) begin
              sample_d    = MIDSCALE;
              pend_d      = 1'b0;
              stop_lat_d  = 1'b0;
              pause_lat_d = 1'b0;
              state_d     = IDLE;
            end else if (pause_any) begin
              pend_d      = 1'b0;
              stop_lat_d  = 1'b0;
              pause_lat_d = 1'b0;
              state_d     = PAUSED;
            end else begin
              mem_req_d = 1'b1;
            end
          end
        end
      end

      PAUSED: begin
        pend_d = 1'b0;
        if (stop) begin
          sample_d = MIDSCALE;
          state_d  = IDLE;
        end else if (play && !pause) begin
          state_d = WAIT_TICK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset back to silence and idle.
  always_ff @(posedge clk_27MHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      mem_req_q   <= 1'b0;
      sample_q    <= MIDSCALE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= 1'b0;
      stop_lat_q  <= 1'b0;
      pause_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      mem_req_q   <= mem_req_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      pend_q      <= pend_d;
      stop_lat_q  <= stop_lat_d;
      pause_lat_q <= pause_lat_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign playing      = running;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Bench for audio_playback_scheduler: small track/tick sizes, a latency-
// programmable memory responder, and a transaction scoreboard of expected
// fetch addresses/times and expected samples computed from the track rules.
module tb_audio_playback_scheduler;

  localparam int TICK_DIV    = 9;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int NUM_TRACKS  = 4;
  localparam int TRACK_WORDS = 4;
  localparam int PERIOD      = TICK_DIV + 1;

  logic              clk_27MHz = 1'b0;
  logic              reset     = 1'b1;
  logic              play      = 1'b0;
  logic              pause     = 1'b0;
  logic              stop      = 1'b0;
  logic              loop_en   = 1'b0;
  logic [1:0]        track_sel = 2'd0;
  logic              mem_ack   = 1'b0;
  logic [DATA_W-1:0] mem_data  = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              playing;
  logic              done;
  logic              overrun;

  audio_playback_scheduler #(
    .TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NUM_TRACKS(NUM_TRACKS), .TRACK_WORDS(TRACK_WORDS), .MIDSCALE(8'h80)
  ) dut (
    .clk_27MHz(clk_27MHz), .reset(reset),
    .play(play), .pause(pause), .stop(stop), .loop_en(loop_en), .track_sel(track_sel),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .playing(playing),
    .done(done), .overrun(overrun)
  );

  initial forever #5 clk_27MHz = ~clk_27MHz;

  int cyc = 0;
  always @(posedge clk_27MHz) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Sample memory contents: a simple address hash, none equal to silence for the tracks used.
  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd29 + 16'd17;
    return t[7:0];
  endfunction

  typedef struct { logic [15:0] addr; int cyc; } rise_t;
  typedef struct { logic [7:0] data; logic done; } vld_t;
  rise_t exp_rise[$];
  vld_t  exp_vld[$];

  task automatic exp_fetch(input int a, input int c);
    exp_rise.push_back('{addr: 16'(a), cyc: c});
  endtask

  task automatic exp_sample(input int a, input logic d);
    exp_vld.push_back('{data: memf(16'(a)), done: d});
  endtask

  // Memory responder: ack arrives lat cycles after the first request cycle.
  int lat = 2;
  int age = 0;
  bit resp_en = 1'b1;
  initial forever begin
    @(posedge clk_27MHz);
    #1;
    if (resp_en) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        age++;
        if (age == lat + 1) begin
          mem_ack  = 1'b1;
          mem_data = memf(mem_addr);
          age      = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Scoreboard: every request start and every strobe against the expectation queues,
  // plus per-cycle invariants on the handshake and the sample register.
  logic              prev_req    = 1'b0;
  logic [ADDR_W-1:0] prev_addr   = '0;
  logic [DATA_W-1:0] prev_sample = 8'h80;
  always @(negedge clk_27MHz) begin
    if (!reset) begin
      if (mem_req && !prev_req) begin
        $display("req   addr=%0d cycle=%0d", mem_addr, cyc);
        if (exp_rise.size() == 0) begin
          chk("req_unexpected", 32'(mem_req), 32'd0);
        end else begin
          chk("req_addr", 32'(mem_addr), 32'(exp_rise[0].addr));
          chk("req_cycle", cyc, exp_rise[0].cyc);
          void'(exp_rise.pop_front());
        end
      end
      if (mem_req && prev_req) chk("req_addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (sample_valid) begin
        $display("strobe sample=0x%02h done=%0b cycle=%0d", sample_out, done, cyc);
        if (exp_vld.size() == 0) begin
          chk("strobe_unexpected", 32'(sample_valid), 32'd0);
        end else begin
          chk("strobe_data", 32'(sample_out), 32'(exp_vld[0].data));
          chk("strobe_done", 32'(done), 32'(exp_vld[0].done));
          void'(exp_vld.pop_front());
        end
      end
      chk("done_with_strobe", 32'(done & ~sample_valid), 32'd0);
      chk("sample_hold", 32'(sample_valid || sample_out == prev_sample || sample_out == 8'h80), 32'd1);
    end
    prev_req    <= mem_req;
    prev_addr   <= mem_addr;
    prev_sample <= sample_out;
  end

  task automatic step();
    @(posedge clk_27MHz);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  int p;
  int r;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'h80);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    step();

    // Basic playback of track 1, no loop
    p = cyc; track_sel = 2'd1; loop_en = 1'b0; play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_fetch(4 + k, p + 11 + PERIOD * k);
      exp_sample(4 + k, k == 3);
    end
    step(); play = 1'b0;
    chk("basic_playing", 32'(playing), 32'd1);
    go_to(p + 14);
    chk("basic_first_sample", 32'(sample_out), 32'h85);
    go_to(p + 44);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_last_sample", 32'(sample_out), 32'hDC);
    chk("basic_playing_end", 32'(playing), 32'd0);
    step();
    chk("basic_silence", 32'(sample_out), 32'h80);
    chk("basic_done_pulse", 32'(done), 32'd0);
    go_to(p + 56);
    chk("basic_idle_req", 32'(mem_req), 32'd0);

    // Looping: addresses wrap 4,5,6,7,4,5 without done
    p = cyc; loop_en = 1'b1; play = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_fetch(4 + (k % 4), p + 11 + PERIOD * k);
      exp_sample(4 + (k % 4), 1'b0);
    end
    step(); play = 1'b0;
    go_to(p + 44);
    chk("loop_no_done", 32'(done), 32'd0);
    chk("loop_playing", 32'(playing), 32'd1);
    go_to(p + 64);
    chk("loop_sample", 32'(sample_out), 32'hA2);
    chk("loop_next_addr", 32'(mem_addr), 32'd6);
    go_to(p + 65); stop = 1'b1; step(); stop = 1'b0;
    chk("loop_stop_playing", 32'(playing), 32'd0);
    chk("loop_stop_silence", 32'(sample_out), 32'h80);
    go_to(p + 75);
    chk("loop_stop_req", 32'(mem_req), 32'd0);

    // Pause three cycles after the second tick, hold, resume
    loop_en = 1'b0; p = cyc; play = 1'b1;
    exp_fetch(4, p + 11); exp_sample(4, 1'b0);
    exp_fetch(5, p + 21); exp_sample(5, 1'b0);
    step(); play = 1'b0;
    go_to(p + 23); pause = 1'b1; step(); pause = 1'b0;
    chk("pause_playing", 32'(playing), 32'd0);
    chk("pause_sample", 32'(sample_out), 32'hA2);
    for (int i = 0; i < 5; i++) begin
      repeat (10) step();
      chk("pause_no_req", 32'(mem_req), 32'd0);
      chk("pause_hold", 32'(sample_out), 32'hA2);
    end
    r = cyc; track_sel = 2'd3;
    exp_fetch(6, r + 8); exp_sample(6, 1'b0);
    exp_fetch(7, r + 18); exp_sample(7, 1'b1);
    play = 1'b1; step(); play = 1'b0; track_sel = 2'd1;
    chk("resume_playing", 32'(playing), 32'd1);
    go_to(r + 7);
    chk("resume_before_tick", 32'(mem_req), 32'd0);
    go_to(r + 8);
    chk("resume_tick_req", 32'(mem_req), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd6);
    go_to(r + 22);
    chk("resume_end_silence", 32'(sample_out), 32'h80);
    chk("resume_end_playing", 32'(playing), 32'd0);

    // Stop while a fetch is outstanding
    lat = 6; p = cyc; play = 1'b1;
    exp_fetch(4, p + 11); exp_sample(4, 1'b0);
    exp_fetch(5, p + 21);
    step(); play = 1'b0;
    go_to(p + 22);
    chk("stopf_req_before", 32'(mem_req), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stopf_req_held", 32'(mem_req), 32'd1);
      chk("stopf_sample_held", 32'(sample_out), 32'h85);
      step();
    end
    chk("stopf_req_dropped", 32'(mem_req), 32'd0);
    chk("stopf_silence", 32'(sample_out), 32'h80);
    chk("stopf_playing", 32'(playing), 32'd0);
    chk("stopf_no_strobe", 32'(sample_valid), 32'd0);
    go_to(p + 40);
    chk("stopf_idle_req", 32'(mem_req), 32'd0);

    // Slow memory: latency 25 forces pending-tick chaining and overrun
    lat = 25; p = cyc; track_sel = 2'd2; play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_fetch(8 + k, p + 11 + 27 * k);
      exp_sample(8 + k, k == 3);
    end
    step(); play = 1'b0;
    go_to(p + 25);
    chk("slow_overrun_clear", 32'(overrun), 32'd0);
    go_to(p + 31);
    chk("slow_overrun_set", 32'(overrun), 32'd1);
    go_to(p + 37);
    chk("slow_reissue_gap", 32'(mem_req), 32'd0);
    chk("slow_playing", 32'(playing), 32'd1);
    go_to(p + 38);
    chk("slow_reissue_req", 32'(mem_req), 32'd1);
    chk("slow_reissue_addr", 32'(mem_addr), 32'd9);
    go_to(p + 118);
    chk("slow_done", 32'(done), 32'd1);
    chk("slow_last_sample", 32'(sample_out), 32'h50);
    go_to(p + 120);
    chk("slow_overrun_sticky", 32'(overrun), 32'd1);
    chk("slow_idle", 32'(playing), 32'd0);
    track_sel = 2'd0; play = 1'b1; step(); play = 1'b0;
    chk("slow_overrun_cleared", 32'(overrun), 32'd0);
    chk("slow_replay_playing", 32'(playing), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("slow_replay_stopped", 32'(playing), 32'd0);

    // Reset while a fetch is outstanding, then a stray ack
    lat = 2; track_sel = 2'd1; p = cyc; play = 1'b1;
    exp_fetch(4, p + 11); exp_sample(4, 1'b0);
    exp_fetch(5, p + 21);
    step(); play = 1'b0;
    go_to(p + 22);
    resp_en = 1'b0;
    chk("rstf_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstf_req", 32'(mem_req), 32'd0);
    chk("rstf_addr", 32'(mem_addr), 32'd0);
    chk("rstf_sample", 32'(sample_out), 32'h80);
    chk("rstf_playing", 32'(playing), 32'd0);
    step(); step();
    reset = 1'b0;
    mem_ack = 1'b0;
    step();
    mem_data = 8'h33; mem_ack = 1'b1; step(); mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_no_strobe", 32'(sample_valid), 32'd0);
      chk("late_ack_sample", 32'(sample_out), 32'h80);
      chk("late_ack_req", 32'(mem_req), 32'd0);
      step();
    end

    chk("all_fetches_seen", exp_rise.size(), 32'd0);
    chk("all_strobes_seen", exp_vld.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_playback_scheduler.md
# audio_playback_scheduler

Sequences sample playback for the jukebox. It derives the ~22 kHz sample tick from clk_27MHz, fetches one sample per tick from sample memory over a req/ack handshake, and presents it to the DAC path with a one-cycle valid strobe. It also owns the play, pause and stop transport controls, track selection and looping for NUM_TRACKS fixed-size tracks in a shared sample memory.

## Interface
- TICK_DIV, 1227: tick period is TICK_DIV+1 clocks (1228 → 21.99 kHz).
- ADDR_W, 16: sample memory address width.
- DATA_W, 8: sample width, unsigned.
- NUM_TRACKS, 4: number of tracks; track_sel width is $clog2(NUM_TRACKS).
- TRACK_WORDS, 16384: samples per track; NUM_TRACKS*TRACK_WORDS ≤ 2^ADDR_W.
- MIDSCALE, 8'h80: silence value driven on sample_out when not playing.
- clk_27MHz, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- play, in, 1: single-cycle pulse; start from IDLE or resume from PAUSED.
- pause, in, 1: single-cycle pulse.
- stop, in, 1: single-cycle pulse.
- loop_en, in, 1: wrap to track start at track end. Sampled at each track end.
- track_sel, in, log2(NUM_TRACKS): track to play. Sampled only when play is accepted in IDLE.
- mem_req, out, 1: fetch request. Held high until mem_ack.
- mem_addr, out, ADDR_W: fetch address. Stable while mem_req is high.
- mem_ack, in, 1: single-cycle; mem_data is valid in the same cycle.
- mem_data, in, DATA_W: sample data.
- sample_out, out, DATA_W: current sample. Registered, holds between strobes.
- sample_valid, out, 1: one-cycle strobe when sample_out updates.
- playing, out, 1: high in WAIT_TICK and FETCH.
- done, out, 1: one-cycle pulse at the end of a non-looping track.
- overrun, out, 1: sticky; set when a tick is lost. Cleared when play is accepted.

## Operation
- States: IDLE, WAIT_TICK, FETCH, PAUSED.
- Reset values: state IDLE, tick counter 0, mem_req 0, mem_addr 0, sample_out MIDSCALE, sample_valid 0, playing 0, done 0, overrun 0, tick_pending 0.
- Control priority when pulses coincide: stop > pause > play.
- IDLE:
  - play → base = track_sel*TRACK_WORDS; addr = base; counter cleared; overrun cleared; go to WAIT_TICK.
  - pause and stop are ignored.
- WAIT_TICK:
  - The counter counts 0..TICK_DIV. A tick fires when the counter equals TICK_DIV; the counter wraps to 0 in the same cycle.
  - On a tick → FETCH, with mem_req=1 and mem_addr=addr.
  - pause → PAUSED. stop → IDLE.
- FETCH:
  - The counter keeps running. A tick occurring here sets tick_pending. A second tick while tick_pending is already set sets overrun, and the tick is dropped.
  - On mem_ack:
    - sample_out ← mem_data; sample_valid=1 in the next cycle; mem_req drops in the next cycle.
    - If addr = base+TRACK_WORDS-1: when loop_en, addr ← base; otherwise done pulses, sample_out ← MIDSCALE, next state IDLE (the final sample is still strobed before the MIDSCALE update).
    - Otherwise addr ← addr+1, with no wrap beyond the track.
    - Next state is FETCH again if tick_pending (tick_pending is cleared), otherwise WAIT_TICK.
  - stop or pause arriving in FETCH is latched and applied after mem_ack. The fetched sample is discarded (no sample_valid) when stop is latched. mem_req is never dropped before ack.
- PAUSED:
  - The counter, addr and sample_out are held. tick_pending is cleared.
  - play → WAIT_TICK, counter resumes from its held value.
  - stop → IDLE.
- Entering IDLE by stop: sample_out ← MIDSCALE, no done pulse, mem_req 0.
- Reset asserted mid-fetch: all outputs return to reset values immediately. A late mem_ack is ignored.

## Timing
- First tick: TICK_DIV+1 cycles after the play-accept edge.
- mem_req rises on the clock edge after the tick cycle.
- Memory latency is arbitrary, ≥1 cycle after mem_req.
- sample_valid rises on the clock edge after the mem_ack cycle.
- Steady-state sample period is exactly TICK_DIV+1 clocks whenever memory latency < TICK_DIV.
- done and sample_valid for the final sample share the same cycle.
- playing deasserts in that same cycle.

## Test plan
- Basic playback (TICK_DIV=9, TRACK_WORDS=4, ack 2 cycles after req, track_sel=1, loop_en=0): play → mem_addr 4,5,6,7 at 10-clock spacing; 4 sample_valid strobes carrying mem_data; done pulse with the 4th strobe; sample_out=0x80 afterwards; IDLE.
- Looping: as above with loop_en=1 → the address sequence 4,5,6,7,4,5 continues; no done pulse.
- Pause/resume: pause 3 cycles after the 2nd tick, hold 50 cycles, then play → no mem_req while paused; sample_out holds; the next tick arrives 7 cycles after resume.
- Stop during fetch: stop while mem_req=1, ack 5 cycles later → mem_req held until ack; no sample_valid; sample_out=0x80; IDLE; playing=0.
- Slow memory: ack latency 25 with TICK_DIV=9 → back-to-back fetches driven by tick_pending; overrun=1 and sticky; cleared on the next accepted play.
- Reset mid-fetch: assert reset while mem_req=1 → mem_req=0, mem_addr=0 and sample_out=0x80 asynchronously; an ack after release has no effect.
